conversor_bin_bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one bit per clock.
- Converts an ALU result to packed BCD digits for the seven-segment display path.
- Generalises the single-digit add-3 correction cell:
  - width-parametrised input;
  - DIGITS correction cells applied in parallel per iteration;
  - signed (two's complement) mode with sign flag;
  - start/busy/done handshake.

---
 rtl/conversor_bin_bcd_seq.sv | 122 ++++++++++++
 tb/tb_conversor_bin_bcd_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conversor_bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional two's complement input with separate sign flag; start/busy/done handshake.
module conversor_bin_bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  negative
);

    localparam int unsigned BCDW = 4 * DIGITS;
    localparam int unsigned CW   = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      bin_q, bin_d;
    logic [BCDW-1:0]       scr_q, scr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sign_q, sign_d;
    logic                  done_q, done_d;
    logic [BCDW-1:0]       bcd_q, bcd_d;
    logic                  neg_q, neg_d;

    logic [WIDTH-1:0]      mag;
    logic [BCDW-1:0]       adj;
    logic [BCDW+WIDTH-1:0] shifted;

    // Magnitude of the request: two's complement negate only for signed negative inputs
    always_comb begin
        mag = bin_in;
        if (signed_mode && bin_in[WIDTH-1]) begin
            mag = ~bin_in + WIDTH'(1);
        end
    end

    // Add-3 correction on every scratch digit >= 5, then shift {scratch, binary} left
    always_comb begin
        adj = scr_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        // Top scratch bit never carries for legal WIDTH/DIGITS, so it is dropped
        shifted = {adj[BCDW-2:0], bin_q, 1'b0};
    end

    // Next-state and datapath update for the IDLE/CONV controller
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = mag;
                    sign_d  = signed_mode & bin_in[WIDTH-1];
                    scr_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = CONV;
                end
            end
            CONV: begin
                scr_d = shifted[BCDW+WIDTH-1:WIDTH];
                bin_d = shifted[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted[BCDW+WIDTH-1:WIDTH];
                    neg_d   = sign_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
        end
    end

    assign busy     = (state_q == CONV);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign negative = neg_q;

endmodule

// File: tb/tb_conversor_bin_bcd_seq.sv
// Scoreboard bench for conversor_bin_bcd_seq: an 8-bit/3-digit and a 16-bit/5-digit instance.
module tb_conversor_bin_bcd_seq;

    typedef struct {
        logic [19:0] bcd;
        logic        neg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8, sm8, busy8, done8, neg8;
    logic [7:0]  bin8;
    logic [11:0] bcd8;

    logic        start16, sm16, busy16, done16, neg16;
    logic [15:0] bin16;
    logic [19:0] bcd16;

    exp_t q8[$];
    exp_t q16[$];
    exp_t hold8, hold16;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    conversor_bin_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8), .negative(neg8)
    );

    conversor_bin_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16), .bin_in(bin16),
        .busy(busy16), .done(done16), .bcd_out(bcd16), .negative(neg16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: decimal digits of the magnitude via plain division
    function automatic exp_t model(input logic [15:0] v, input logic sm, input int w);
        exp_t        e;
        longint      mag;
        mag   = longint'(v) & ((longint'(1) << w) - 1);
        e.neg = sm && v[w-1];
        if (e.neg) mag = (longint'(1) << w) - mag;
        e.bcd = '0;
        for (int i = 0; i < 5; i++) begin
            e.bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done, otherwise outputs must hold
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold8  = '{bcd: '0, neg: 1'b0};
            hold16 = '{bcd: '0, neg: 1'b0};
            check("rst_busy8", {31'd0, busy8}, 32'd0);
            check("rst_done8", {31'd0, done8}, 32'd0);
            check("rst_bcd8", {20'd0, bcd8}, 32'd0);
            check("rst_neg8", {31'd0, neg8}, 32'd0);
            check("rst_busy16", {31'd0, busy16}, 32'd0);
            check("rst_bcd16", {12'd0, bcd16}, 32'd0);
        end else begin
            if (done8) begin
                if (q8.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done8 @%0t: got done with bcd %h, required no done", $time, bcd8);
                end else begin
                    e = q8.pop_front();
                    check("bcd8", {20'd0, bcd8}, {20'd0, e.bcd[11:0]});
                    check("neg8", {31'd0, neg8}, {31'd0, e.neg});
                    hold8 = e;
                end
            end else begin
                check("hold_bcd8", {20'd0, bcd8}, {20'd0, hold8.bcd[11:0]});
                check("hold_neg8", {31'd0, neg8}, {31'd0, hold8.neg});
            end
            if (done16) begin
                if (q16.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done16 @%0t: got done with bcd %h, required no done", $time, bcd16);
                end else begin
                    e = q16.pop_front();
                    check("bcd16", {12'd0, bcd16}, {12'd0, e.bcd});
                    check("neg16", {31'd0, neg16}, {31'd0, e.neg});
                    hold16 = e;
                end
            end else begin
                check("hold_bcd16", {12'd0, bcd16}, {12'd0, hold16.bcd});
                check("hold_neg16", {31'd0, neg16}, {31'd0, hold16.neg});
            end
        end
    end

    // Present one request for a single cycle; returns #1 after the accepting edge
    task automatic issue(input int sel, input logic [15:0] v, input logic sm);
        exp_t e;
        e = model(v, sm, (sel == 0) ? 8 : 16);
        @(negedge clk);
        if (sel == 0) begin
            start8 = 1'b1; bin8 = v[7:0]; sm8 = sm; q8.push_back(e);
        end else begin
            start16 = 1'b1; bin16 = v; sm16 = sm; q16.push_back(e);
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start16 = 1'b0;
        bin8    = 8'($urandom);
        sm8     = 1'($urandom);
        bin16   = 16'($urandom);
        sm16    = 1'($urandom);
    endtask

    // Count edges until done is seen (bounded), and busy cycles along the way
    task automatic wait_done(input int sel, output int k, output int bc);
        k  = 0;
        bc = 0;
        while (k < 40) begin
            if ((sel == 0) ? busy8 : busy16) bc++;
            if ((sel == 0) ? done8 : done16) break;
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic convert(input int sel, input logic [15:0] v, input logic sm);
        int k, bc, w;
        w = (sel == 0) ? 8 : 16;
        issue(sel, v, sm);
        wait_done(sel, k, bc);
        check("done_latency", k, w);
        check("busy_cycles", bc, w);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bc;
        int sel;
        start8 = 1'b0; sm8 = 1'b0; bin8 = '0;
        start16 = 1'b0; sm16 = 1'b0; bin16 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed 8-bit cases including most-negative and zero in both modes
        convert(0, 16'd255, 1'b0);
        convert(0, 16'h80, 1'b1);
        convert(0, 16'hF6, 1'b1);
        convert(0, 16'h7F, 1'b1);
        convert(0, 16'd0, 1'b0);
        convert(0, 16'hF6, 1'b0);
        convert(0, 16'd0, 1'b1);

        // Start during busy is ignored; start in the done cycle is accepted
        issue(0, 16'd99, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start8 = 1'b1; bin8 = 8'd7; sm8 = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done(0, k, bc);
        check("done_after_ignored_start", {31'd0, done8}, 32'd1);
        issue(0, 16'd42, 1'b0);
        wait_done(0, k, bc);
        check("b2b_gap", k + 1, 9);

        // Reset in the middle of a conversion aborts it with no done
        issue(0, 16'd200, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q8.delete();
        #1;
        check("abort_busy8", {31'd0, busy8}, 32'd0);
        check("abort_done8", {31'd0, done8}, 32'd0);
        check("abort_bcd8", {20'd0, bcd8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        convert(0, 16'd5, 1'b0);

        // Directed 16-bit cases
        convert(1, 16'hFFFF, 1'b0);
        convert(1, 16'h8000, 1'b1);
        convert(1, 16'h0000, 1'b1);
        convert(1, 16'hFFFF, 1'b1);

        // Randomized mix across both instances
        repeat (150) begin
            sel = int'($urandom_range(0, 1));
            convert(sel, 16'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        check("q8_drained", q8.size(), 0);
        check("q16_drained", q16.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
